// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Sends one idle-high asynchronous frame per accepted tx_start:
// start bit, DATA_W data bits LSB first, optional parity bit, STOP_BITS stop
// bits, each bit CLKS_PER_BIT clock cycles wide.
//
// Compile-time option: define UART_TX_PARITY_EN to add the parity bit
// (even when PARITY_ODD=0, odd when PARITY_ODD=1). Undefined: no parity slot.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_start  send request, sampled only while idle
//   data_in   word to send, captured on the accepting edge
//   data_out  registered serial line, idle high
//   tx_busy   high from the accepting edge until the frame completes
//   tx_done   one-cycle pulse at frame completion
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..16");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;     // data bit index, reused as stop bit index
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              line_n;
    logic              done_n;
    logic              tc;
`ifdef UART_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign tx_busy = (state != IDLE);
    assign tc      = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            data_out <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            data_out <= line_n;
            tx_done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    // The line is registered, so line_n is the level of the state being
    // entered (or the next bit of the current state); this makes the start
    // bit appear on the accepting edge itself.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        line_n  = data_out;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                cnt_n  = '0;
                line_n = 1'b1;
                if (tx_start) begin
                    shreg_n = data_in;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^data_in) ^ (PARITY_ODD != 0);
`endif
                    state_n = START;
                    line_n  = 1'b0;
                end
            end
            START: begin
                if (tc) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                    line_n  = shreg[0];
                end
            end
            DATA: begin
                if (tc) begin
                    cnt_n = '0;
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        line_n  = par;
`else
                        state_n = STOP;
                        line_n  = 1'b1;
`endif
                    end else begin
                        // shreg[0] is the bit on the line; shift and present the next one
                        idx_n   = idx + 1'b1;
                        shreg_n = shreg >> 1;
                        line_n  = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tc) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    line_n  = 1'b1;
                end
            end
`endif
            STOP: begin
                line_n = 1'b1;
                if (tc) begin
                    cnt_n = '0;
                    if (idx == STOP_LAST) begin
                        idx_n   = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                line_n  = 1'b1;
            end
        endcase
    end

endmodule
